// File: rtl/wb_servo_controller.sv
// wb_servo_controller: Wishbone classic slave driving one hobby-servo PWM pin.
// A free-running frame counter compares against a double-buffered pulse width.
//
// Ports:
//   wb_clk, wb_rst            clock, async active-high reset
//   wb_cyc, wb_stb, wb_we     Wishbone classic cycle / strobe / write enable
//   wb_sel[3:0]               write byte enables
//   wb_adr[31:0]              byte address, only [3:2] decoded (map aliases)
//   wb_dat_i[31:0]            write data
//   pwm_out                   registered servo PWM output
//   wb_ack                    registered one-cycle acknowledge
//   wb_dat_o[31:0]            registered read data
//   debug_counter[31:0]       frame counter
//   debug_pwm_width_reg[31:0] programmed WIDTH (not the active copy)
//
// Register map: 0x00 PERIOD (RW), 0x04 WIDTH (RW), 0x08 COUNTER (RO),
//               0x0C ACTIVE_WIDTH (RO).
// Build option: define SERVO_WIDTH_CLAMP_EN to saturate WIDTH writes (and the
// reset value) into [MIN_WIDTH, MAX_WIDTH].

module wb_servo_controller #(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter logic [31:0] DEFAULT_PERIOD = 32'd2_000_000,
   parameter logic [31:0] DEFAULT_WIDTH  = 32'd0,
   parameter logic [31:0] MIN_WIDTH      = 32'd100_000,
   parameter logic [31:0] MAX_WIDTH      = 32'd200_000
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat_i,
   output logic        pwm_out,
   output logic        wb_ack,
   output logic [31:0] wb_dat_o,
   output logic [31:0] debug_counter,
   output logic [31:0] debug_pwm_width_reg
);

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old,
      input logic [31:0] dat,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
      end
      return r;
   endfunction

`ifdef SERVO_WIDTH_CLAMP_EN
   function automatic logic [31:0] limit_width(input logic [31:0] v);
      if (v < MIN_WIDTH)      return MIN_WIDTH;
      else if (v > MAX_WIDTH) return MAX_WIDTH;
      else                    return v;
   endfunction
`else
   function automatic logic [31:0] limit_width(input logic [31:0] v);
      return v;
   endfunction
`endif

   localparam logic [31:0] RST_WIDTH = limit_width(DEFAULT_WIDTH);

   logic [31:0] period;
   logic [31:0] width;
   logic [31:0] active_width;
   logic [31:0] counter;
   logic        req;
   logic        wrap;
   logic [31:0] width_wr;
   logic [31:0] rd_mux;

   // A transfer is taken only while no ack is outstanding, so every
   // strobe yields exactly one single-cycle ack.
   assign req = wb_cyc & wb_stb & ~wb_ack;

   // Wrap compares against the live PERIOD, so shrinking PERIOD below the
   // current count forces a wrap on the next cycle.
   assign wrap = (period == 32'd0) || (counter >= period - 32'd1);

   assign width_wr = limit_width(merge_bytes(width, wb_dat_i, wb_sel));

   always_comb begin
      rd_mux = 32'd0;
      unique case (wb_adr[3:2])
         2'd0: rd_mux = period;
         2'd1: rd_mux = width;
         2'd2: rd_mux = counter;
         2'd3: rd_mux = active_width;
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         period       <= DEFAULT_PERIOD;
         width        <= RST_WIDTH;
         active_width <= RST_WIDTH;
         counter      <= 32'd0;
         pwm_out      <= 1'b0;
         wb_ack       <= 1'b0;
         wb_dat_o     <= 32'd0;
      end else begin
         wb_ack <= req;
         if (req && wb_we) begin
            unique case (wb_adr[3:2])
               2'd0: period <= merge_bytes(period, wb_dat_i, wb_sel);
               2'd1: width  <= width_wr;
               default: ;
            endcase
         end
         if (req && !wb_we) wb_dat_o <= rd_mux;

         counter <= wrap ? 32'd0 : counter + 32'd1;
         // Double buffer: a new width only takes effect at a frame boundary.
         if (wrap) active_width <= width;
         pwm_out <= (period != 32'd0) && (counter < active_width);
      end
   end

   assign debug_counter       = counter;
   assign debug_pwm_width_reg = width;

   logic unused;
   assign unused = ^{wb_adr[31:4], wb_adr[1:0], CLK_HZ[0],
                     MIN_WIDTH[0], MAX_WIDTH[0]};

endmodule

// File: tb/tb_wb_servo_controller.sv
// Directed testbench for wb_servo_controller (default build, no clamp).
// Frames use a short programmed PERIOD to keep run time small.

module tb_wb_servo_controller;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic        wb_we  = 1'b0;
   logic [3:0]  wb_sel = 4'h0;
   logic [31:0] wb_adr = 32'd0;
   logic [31:0] wb_dat_i = 32'd0;
   logic        pwm_out;
   logic        wb_ack;
   logic [31:0] wb_dat_o;
   logic [31:0] debug_counter;
   logic [31:0] debug_pwm_width_reg;

   int checks = 0;
   int errors = 0;

   wb_servo_controller dut (
      .wb_clk(wb_clk),
      .wb_rst(wb_rst),
      .wb_cyc(wb_cyc),
      .wb_stb(wb_stb),
      .wb_we(wb_we),
      .wb_sel(wb_sel),
      .wb_adr(wb_adr),
      .wb_dat_i(wb_dat_i),
      .pwm_out(pwm_out),
      .wb_ack(wb_ack),
      .wb_dat_o(wb_dat_o),
      .debug_counter(debug_counter),
      .debug_pwm_width_reg(debug_pwm_width_reg)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                  tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic bus_end();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (wb_ack) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b1;
      wb_adr = adr;
      wb_dat_i = dat;
      wb_sel = sel;
      wait_ack("wr");
      bus_end();
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b0;
      wb_adr = adr;
      wait_ack("rd");
      dat = wb_dat_o;
      bus_end();
   endtask

   task automatic wait_wrap(input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (debug_counter == 32'd0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("wrap_timeout", 32'd0, 32'd1);
   endtask

   // Counts pwm_out highs over one frame; optionally writes WIDTH mid-frame.
   task automatic measure(input int p, input bit do_wr,
                          input logic [31:0] wdat, output int hi);
      wait_wrap(2 * p + 10);
      hi = 0;
      for (int i = 0; i < p; i++) begin
         if (do_wr && i == 20) begin
            wb_cyc = 1'b1;
            wb_stb = 1'b1;
            wb_we  = 1'b1;
            wb_adr = 32'h4;
            wb_dat_i = wdat;
            wb_sel = 4'hF;
         end
         step();
         if (do_wr && i == 20) begin
            check("midframe_ack", {31'd0, wb_ack}, 32'd1);
            bus_end();
         end
         if (pwm_out) hi++;
      end
   endtask

   logic [31:0] rd;
   int hi;
   int acks;

   initial begin
      #3;
      check("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check("rst_ack", {31'd0, wb_ack}, 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      check("rst_cnt", debug_counter, 32'd0);
      check("rst_width", debug_pwm_width_reg, 32'd0);
      #97;
      wb_rst = 1'b0;
      step();

      wb_read(32'h0, rd);
      check("rd_period_dflt", rd, 32'd2_000_000);
      wb_read(32'hC, rd);
      check("rd_active_dflt", rd, 32'd0);
      check("idle_pwm", {31'd0, pwm_out}, 32'd0);

      repeat (150) step();
      wb_write(32'h0, 32'd100, 4'hF);
      step();
      check("ack_one_cycle", {31'd0, wb_ack}, 32'd0);
      check("period_shrink_wrap", debug_counter, 32'd0);

      wait_wrap(300);
      repeat (99) step();
      check("cnt_last", debug_counter, 32'd99);
      step();
      check("cnt_wrap", debug_counter, 32'd0);

      wb_write(32'h0, 32'd1000, 4'hF);
      wb_write(32'h4, 32'h80, 4'hF);
      measure(1000, 1'b0, 32'd0, hi);
      check("w128", hi, 32'd128);
      measure(1000, 1'b1, 32'h100, hi);
      check("w128_frame_kept", hi, 32'd128);
      measure(1000, 1'b0, 32'd0, hi);
      check("w256_next", hi, 32'd256);

      wb_write(32'h4, 32'd1000, 4'hF);
      measure(1000, 1'b0, 32'd0, hi);
      check("w_eq_p_high", hi, 32'd1000);
      wb_write(32'h4, 32'd2000, 4'hF);
      measure(1000, 1'b0, 32'd0, hi);
      check("w_gt_p_high", hi, 32'd1000);
      wb_write(32'h4, 32'd0, 4'hF);
      measure(1000, 1'b0, 32'd0, hi);
      check("w0_low", hi, 32'd0);

      wb_write(32'h4, 32'h0000_1200, 4'hF);
      wb_write(32'h4, 32'h0000_FFFF, 4'b0001);
      check("sel_dbg", debug_pwm_width_reg, 32'h0000_12FF);
      wb_read(32'h4, rd);
      check("sel_rd", rd, 32'h0000_12FF);

      wb_write(32'h8, 32'd5, 4'hF);
      wb_read(32'h0, rd);
      check("cnt_wr_ign_p", rd, 32'd1000);
      check("cnt_wr_ign_w", debug_pwm_width_reg, 32'h0000_12FF);

      wb_write(32'h0, 32'd0, 4'hF);
      wb_write(32'h4, 32'h33, 4'hF);
      repeat (3) step();
      check("p0_cnt", debug_counter, 32'd0);
      check("p0_pwm", {31'd0, pwm_out}, 32'd0);
      wb_read(32'hC, rd);
      check("p0_active", rd, 32'h33);
      wb_read(32'h1C, rd);
      check("alias_active", rd, 32'h33);

      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b0;
      wb_adr = 32'h4;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (wb_ack) acks++;
      end
      bus_end();
      check("b2b_acks", acks, 32'd3);
      check("b2b_dat", wb_dat_o, 32'h33);

      wb_write(32'h0, 32'd1000, 4'hF);
      wb_write(32'h4, 32'd500, 4'hF);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            step();
            if (pwm_out) begin
               seen = 1'b1;
               break;
            end
         end
         check("pulse_seen", {31'd0, seen}, 32'd1);
      end
      repeat (5) step();
      #2;
      wb_rst = 1'b1;
      #1;
      check("async_rst_pwm", {31'd0, pwm_out}, 32'd0);
      check("async_rst_w", debug_pwm_width_reg, 32'd0);
      check("async_rst_cnt", debug_counter, 32'd0);
      repeat (2) @(negedge wb_clk);
      wb_rst = 1'b0;
      step();
      wb_read(32'h0, rd);
      check("post_rst_period", rd, 32'd2_000_000);
      wb_read(32'h4, rd);
      check("post_rst_width", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_servo_controller.md
# wb_servo_controller

Wishbone-slave hobby-servo PWM generator. A free-running cycle counter defines the PWM frame, and a programmable high-time width defines the pulse. Software on the Wishbone bus writes the frame period and pulse width. `pwm_out` drives one servo signal pin. Debug ports expose the counter and width register for bring-up and simulation.

## Interface
- `CLK_HZ`, 100_000_000, clock frequency; informational only.
- `DEFAULT_PERIOD`, 2_000_000, reset value of the period register in cycles (20 ms at 100 MHz).
- `DEFAULT_WIDTH`, 0, reset value of the width register in cycles.
- `MIN_WIDTH` / `MAX_WIDTH`, 100_000 / 200_000, clamp limits, used only when clamping is compiled in.
- `wb_clk` in 1: single clock; all logic on the rising edge.
- `wb_rst` in 1: reset, asynchronous and active-high.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: Wishbone classic cycle, strobe and write enable.
- `wb_sel` in 4: byte enables for writes.
- `wb_adr` in 32: byte address; only `wb_adr[3:2]` is decoded, so the map aliases.
- `wb_dat_i` in 32: write data.
- `pwm_out` out 1: servo PWM output, registered.
- `wb_ack` out 1: transfer acknowledge, registered.
- `wb_dat_o` out 32: read data, registered.
- `debug_counter` out 32: current frame counter value.
- `debug_pwm_width_reg` out 32: programmed width register.

## Operation
- Register map:
  - 0x00 PERIOD, R/W.
  - 0x04 WIDTH, R/W.
  - 0x08 COUNTER, read-only; writes are ignored.
  - 0x0C ACTIVE_WIDTH, read-only; the width currently in use.
- Writes honour `wb_sel` per byte.
- The counter counts 0 … PERIOD−1, then wraps to 0.
- If PERIOD = 0, the counter is held at 0 and `pwm_out` stays 0.
- The width is double-buffered. ACTIVE_WIDTH loads from WIDTH when the counter wraps to 0, so a new pulse width never changes the current frame.
- ACTIVE_WIDTH also loads directly from WIDTH while PERIOD = 0.
- `pwm_out` is 1 for exactly ACTIVE_WIDTH cycles per frame, starting at count 0.
  - ACTIVE_WIDTH = 0 → constant low.
  - ACTIVE_WIDTH ≥ PERIOD → constant high.
- A PERIOD write takes effect immediately. If the counter is already ≥ the new PERIOD−1, it wraps to 0 on the next cycle.
- `debug_counter` = counter; `debug_pwm_width_reg` = WIDTH, not ACTIVE_WIDTH.

## Timing
- Reset values:
  - counter 0, PERIOD = `DEFAULT_PERIOD`, WIDTH = ACTIVE_WIDTH = `DEFAULT_WIDTH`.
  - `pwm_out`, `wb_ack` and `wb_dat_o` are all 0.
- Bus handshake:
  - The block registers a request when `wb_cyc & wb_stb & ~wb_ack` is true at a clock edge.
  - `wb_ack` goes high for exactly one cycle, on the following edge.
  - The write commits, or `wb_dat_o` becomes valid, on that same edge.
  - The block never stalls and never errors.
- Back-to-back transfers: if the master holds `stb` high through the ack, a new transfer starts one cycle after the ack drops. Repeated writes of the same data are harmless.
- `pwm_out` lags the counter by one cycle: `pwm_out` at t+1 equals (counter(t) < ACTIVE_WIDTH(t)).
- With PERIOD = P and width W, the output is high for W cycles and low for P−W cycles, every frame.
- A WIDTH write during a frame leaves that frame unchanged. The new width appears on the first pulse after the next wrap.
- Reset asserted mid-frame:
  - `pwm_out` goes low immediately (asynchronously).
  - All registers return to their reset values.
  - An in-flight ack is dropped.

## Configuration
- `SERVO_WIDTH_CLAMP_EN`
- Defined:
  - A WIDTH write is saturated into [`MIN_WIDTH`, `MAX_WIDTH`] before storage; readback returns the clamped value.
  - The reset value is also clamped.
  - This protects servos from out-of-range pulses.
- Undefined: WIDTH stores any 32-bit value unmodified.

## Test plan
- Reset for 100 ns, then idle: `pwm_out` = 0 continuously; `debug_counter` wraps at 1_999_999; a read of 0x00 returns 2_000_000.
- Write 0x00010000 to 0x04: `wb_ack` is a one-cycle pulse. After the next frame boundary, the high time is 655_360 ns and the low time is 19_344_640 ns, repeating.
- Five successive writes to 0x04, each adding 0x10000, spaced 100 ms apart: the high time steps 655_360 → 1_310_720 → … → 3_276_800 ns, with the period fixed at 20 ms. With the clamp compiled in, the high time saturates at 2_000_000 ns.
- Write WIDTH = 0x100 mid-frame while ACTIVE_WIDTH = 0x80: the current frame's pulse is 128 cycles and the next is 256 cycles.
- Write PERIOD = 10, then WIDTH = 10 and WIDTH = 0: `pwm_out` is constant high, then constant low. Writing 0x0000FFFF to 0x04 with `wb_sel` = 4'b0001 updates only byte 0.
- Assert `wb_rst` mid-pulse: `pwm_out` drops without waiting for a clock edge; PERIOD and WIDTH return to 2_000_000 and 0.
